// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one registered-read ROM
// between two requesters; issue, wait latency, return word.
module rom_arbiter #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 4,
   parameter int ROM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   localparam int CNT_W = 2;

   state_e              state_q, state_d;
   logic                rr_q, rr_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                any_req;
   logic                win;

   // Winner: lone requester, or rr pointer on a tie
   always_comb begin
      any_req = req0 | req1;
      win     = (req0 & req1) ? rr_q : req1;
   end

   // Next-state, grant capture, latency count, data capture
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (any_req) begin
               state_d = ISSUE;
               owner_d = win;
               addr_d  = win ? addr1 : addr0;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            rr_d    = ~owner_q;
            cnt_d   = CNT_W'(ROM_LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = rom_data;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         owner_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      busy     = (state_q != IDLE);
      rom_en   = (state_q == ISSUE);
      rom_addr = addr_q;
      rdata    = rdata_q;
      ack0     = (state_q == ISSUE) & ~owner_q;
      ack1     = (state_q == ISSUE) &  owner_q;
      rvalid0  = (state_q == RESP)  & ~owner_q;
      rvalid1  = (state_q == RESP)  &  owner_q;
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector bench for rom_arbiter,
// latency-1 and latency-3 instances driven in parallel.
module tb_rom_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] addr0 = 4'h0, addr1 = 4'h0;

   logic       ack0_a, ack1_a, rv0_a, rv1_a, busy_a, en_a;
   logic [3:0] raddr_a, rdata_a, rom_a;
   logic       ack0_b, ack1_b, rv0_b, rv1_b, busy_b, en_b;
   logic [3:0] raddr_b, rdata_b, rom_b;

   logic [3:0] rom_a_q = 4'h0;
   logic [3:0] pipe_b0 = 4'h0, pipe_b1 = 4'h0, pipe_b2 = 4'h0;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rom_arbiter #(.ADDR_W(4), .DATA_W(4), .ROM_LATENCY(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .ack0(ack0_a), .rvalid0(rv0_a),
      .req1(req1), .addr1(addr1), .ack1(ack1_a), .rvalid1(rv1_a),
      .rdata(rdata_a), .busy(busy_a),
      .rom_en(en_a), .rom_addr(raddr_a), .rom_data(rom_a)
   );

   rom_arbiter #(.ADDR_W(4), .DATA_W(4), .ROM_LATENCY(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .ack0(ack0_b), .rvalid0(rv0_b),
      .req1(req1), .addr1(addr1), .ack1(ack1_b), .rvalid1(rv1_b),
      .rdata(rdata_b), .busy(busy_b),
      .rom_en(en_b), .rom_addr(raddr_b), .rom_data(rom_b)
   );

   // ROM models: data = addr ^ 4'hF, latency 1 and 3
   always @(posedge clk) begin
      if (en_a) rom_a_q <= raddr_a ^ 4'hF;
      if (en_b) pipe_b0 <= raddr_b ^ 4'hF;
      pipe_b1 <= pipe_b0;
      pipe_b2 <= pipe_b1;
   end
   assign rom_a = rom_a_q;
   assign rom_b = pipe_b2;

   typedef struct {
      logic       rst;
      logic       r0;
      logic [3:0] a0;
      logic       r1;
      logic [3:0] a1;
      logic [13:0] exp;
   } vec_t;

   function automatic vec_t mk(
      input logic rst, input logic r0, input logic [3:0] a0,
      input logic r1, input logic [3:0] a1,
      input logic k0, input logic k1, input logic v0, input logic v1,
      input logic bz, input logic en,
      input logic [3:0] ra, input logic [3:0] rd);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
      v.exp = {k0, k1, v0, v1, bz, en, ra, rd};
      return v;
   endfunction

   function automatic logic [13:0] outs(input logic sel);
      if (sel)
         return {ack0_b, ack1_b, rv0_b, rv1_b, busy_b, en_b, raddr_b, rdata_b};
      return {ack0_a, ack1_a, rv0_a, rv1_a, busy_a, en_a, raddr_a, rdata_a};
   endfunction

   task automatic chk(input string nm, input logic [13:0] act,
                      input logic [13:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // One cycle: optional reset pulse, drive inputs, check at negedge
   task automatic step(input string nm, input vec_t v, input logic sel);
      @(posedge clk);
      #1;
      if (v.rst) begin
         rst_n = 1'b0;
         #1;
         rst_n = 1'b1;
      end
      req0 = v.r0; addr0 = v.a0; req1 = v.r1; addr1 = v.a1;
      @(negedge clk);
      chk(nm, outs(sel), v.exp);
   endtask

   vec_t tbl[$];
   vec_t lat3[$];

   initial begin
      // single request, then reset; simultaneous; boundaries; rr loss
      tbl.push_back(mk(0,1,4'hA,0,4'h0, 0,0,0,0,0,0,4'h0,4'h0));
      tbl.push_back(mk(0,1,4'hA,0,4'h0, 1,0,0,0,1,1,4'hA,4'h0));
      tbl.push_back(mk(0,0,4'hA,0,4'h0, 0,0,0,0,1,0,4'hA,4'h0));
      tbl.push_back(mk(0,0,4'hA,0,4'h0, 0,0,1,0,1,0,4'hA,4'h5));
      tbl.push_back(mk(0,0,4'hA,0,4'h0, 0,0,0,0,0,0,4'hA,4'h5));
      tbl.push_back(mk(1,1,4'h6,1,4'h3, 0,0,0,0,0,0,4'h0,4'h0));
      tbl.push_back(mk(0,1,4'h6,1,4'h3, 1,0,0,0,1,1,4'h6,4'h0));
      tbl.push_back(mk(0,0,4'h6,1,4'h3, 0,0,0,0,1,0,4'h6,4'h0));
      tbl.push_back(mk(0,0,4'h6,1,4'h3, 0,0,1,0,1,0,4'h6,4'h9));
      tbl.push_back(mk(0,0,4'h6,1,4'h3, 0,1,0,0,1,1,4'h3,4'h9));
      tbl.push_back(mk(0,0,4'h6,0,4'h3, 0,0,0,0,1,0,4'h3,4'h9));
      tbl.push_back(mk(0,0,4'h6,0,4'h3, 0,0,0,1,1,0,4'h3,4'hC));
      tbl.push_back(mk(0,0,4'h6,0,4'h3, 0,0,0,0,0,0,4'h3,4'hC));
      tbl.push_back(mk(1,1,4'h0,0,4'h0, 0,0,0,0,0,0,4'h0,4'h0));
      tbl.push_back(mk(0,1,4'h8,0,4'h0, 1,0,0,0,1,1,4'h0,4'h0));
      tbl.push_back(mk(0,0,4'h8,0,4'h0, 0,0,0,0,1,0,4'h0,4'h0));
      tbl.push_back(mk(0,1,4'hF,0,4'h0, 0,0,1,0,1,0,4'h0,4'hF));
      tbl.push_back(mk(0,1,4'h8,0,4'h0, 1,0,0,0,1,1,4'hF,4'hF));
      tbl.push_back(mk(0,0,4'h8,0,4'h0, 0,0,0,0,1,0,4'hF,4'hF));
      tbl.push_back(mk(0,0,4'h8,0,4'h0, 0,0,1,0,1,0,4'hF,4'h0));
      tbl.push_back(mk(0,0,4'h8,0,4'h0, 0,0,0,0,0,0,4'hF,4'h0));
      tbl.push_back(mk(1,1,4'h4,0,4'h0, 0,0,0,0,0,0,4'h0,4'h0));
      tbl.push_back(mk(0,1,4'h4,0,4'h0, 1,0,0,0,1,1,4'h4,4'h0));
      tbl.push_back(mk(0,0,4'h4,1,4'h7, 0,0,0,0,1,0,4'h4,4'h0));
      tbl.push_back(mk(0,1,4'h5,1,4'h7, 0,0,1,0,1,0,4'h4,4'hB));
      tbl.push_back(mk(0,1,4'h5,1,4'h7, 0,1,0,0,1,1,4'h7,4'hB));
      tbl.push_back(mk(0,1,4'h5,0,4'h7, 0,0,0,0,1,0,4'h7,4'hB));
      tbl.push_back(mk(0,1,4'h5,0,4'h7, 0,0,0,1,1,0,4'h7,4'h8));
      tbl.push_back(mk(0,1,4'h5,0,4'h7, 1,0,0,0,1,1,4'h5,4'h8));
      tbl.push_back(mk(0,0,4'h5,0,4'h7, 0,0,0,0,1,0,4'h5,4'h8));
      tbl.push_back(mk(0,0,4'h5,0,4'h7, 0,0,1,0,1,0,4'h5,4'hA));
      tbl.push_back(mk(0,0,4'h5,0,4'h7, 0,0,0,0,0,0,4'h5,4'hA));

      lat3.push_back(mk(1,0,4'h0,1,4'h2, 0,0,0,0,0,0,4'h0,4'h0));
      lat3.push_back(mk(0,0,4'h0,1,4'h2, 0,1,0,0,1,1,4'h2,4'h0));
      lat3.push_back(mk(0,0,4'h0,0,4'h2, 0,0,0,0,1,0,4'h2,4'h0));
      lat3.push_back(mk(0,0,4'h0,0,4'h2, 0,0,0,0,1,0,4'h2,4'h0));
      lat3.push_back(mk(0,0,4'h0,0,4'h2, 0,0,0,0,1,0,4'h2,4'h0));
      lat3.push_back(mk(0,0,4'h0,0,4'h2, 0,0,0,1,1,0,4'h2,4'hD));
      lat3.push_back(mk(0,0,4'h0,0,4'h2, 0,0,0,0,0,0,4'h2,4'hD));

      // reset held with both requests high
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
      addr0 = 4'h5; addr1 = 4'h9;
      repeat (3) @(negedge clk);
      chk("reset_a", outs(1'b0), 14'h0);
      chk("reset_b", outs(1'b1), 14'h0);
      req0 = 1'b0; req1 = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), tbl[i], 1'b0);

      // fairness: both held for 8 transactions
      step("fair_start",
           mk(1,1,4'h1,1,4'h2, 0,0,0,0,0,0,4'h0,4'h0), 1'b0);
      for (int t = 1; t <= 24; t++) begin
         int k, ph;
         logic own;
         logic [3:0] rd;
         k = (t - 1) / 3;
         ph = (t - 1) % 3;
         own = k[0];
         if (ph == 2) rd = own ? 4'hD : 4'hE;
         else if (k == 0) rd = 4'h0;
         else rd = own ? 4'hE : 4'hD;
         step($sformatf("fair%0d", t),
              mk(0, t < 24, 4'h1, t < 24, 4'h2,
                 ph == 0 && !own, ph == 0 && own,
                 ph == 2 && !own, ph == 2 && own,
                 1'b1, ph == 0, own ? 4'h2 : 4'h1, rd), 1'b0);
         n_chk++;
         if (!(ack0_a && ack1_a) && !(rv0_a && rv1_a)) n_pass++;
         else $display("FAIL excl%0d: ack %b%b rvalid %b%b", t,
                       ack0_a, ack1_a, rv0_a, rv1_a);
      end
      step("fair_end",
           mk(0,0,4'h1,0,4'h2, 0,0,0,0,0,0,4'h2,4'hD), 1'b0);

      // reset in the middle of WAIT
      step("mid_c0", mk(1,0,4'h0,1,4'h9, 0,0,0,0,0,0,4'h0,4'h0), 1'b0);
      step("mid_c1", mk(0,0,4'h0,1,4'h9, 0,1,0,0,1,1,4'h9,4'h0), 1'b0);
      step("mid_c2", mk(0,1,4'hC,1,4'h9, 0,0,0,0,1,0,4'h9,4'h0), 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_now", outs(1'b0), 14'h0);
      @(negedge clk);
      chk("mid_rst_hold", outs(1'b0), 14'h0);
      rst_n = 1'b1;
      step("mid_r1", mk(0,0,4'hC,0,4'h9, 1,0,0,0,1,1,4'hC,4'h0), 1'b0);
      step("mid_r2", mk(0,0,4'hC,0,4'h9, 0,0,0,0,1,0,4'hC,4'h0), 1'b0);
      step("mid_r3", mk(0,0,4'hC,0,4'h9, 0,0,1,0,1,0,4'hC,4'h3), 1'b0);

      // latency 3 instance
      for (int i = 0; i < lat3.size(); i++)
         step($sformatf("lat3_%0d", i), lat3[i], 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
